// File: rtl/align_ctrl_if.sv
// Command, memory-read and PE-array signals between align_ctrl and its surroundings.
// No storage: wires only.
// Back-pressure is carried by the hold signal; the reference read data must stay stable until the next strobe.
interface align_ctrl_if #(
   parameter int B = 4
);
   logic           start;
   logic           abort;
   logic           hold;
   logic           qry_rd_en;
   logic [7:0]     qry_addr;
   logic [1:0]     qry_rdata;
   logic           ref_rd_en;
   logic [7:0]     ref_addr;
   logic [1:0]     ref_rdata;
   logic [7:0]     ctr;
   logic [1:0]     region;
   logic [1:0]     diag;
   logic [2*B-1:0] r_bus;
   logic [2*B-1:0] q_bus;
   logic           busy;
   logic           done;

   // Controller side
   modport slave (
      input  start, abort, hold, qry_rdata, ref_rdata,
      output qry_rd_en, qry_addr, ref_rd_en, ref_addr,
             ctr, region, diag, r_bus, q_bus, busy, done
   );

   // Host / memory side
   modport master (
      output start, abort, hold, qry_rdata, ref_rdata,
      input  qry_rd_en, qry_addr, ref_rd_en, ref_addr,
             ctr, region, diag, r_bus, q_bus, busy, done
   );
endinterface

// File: rtl/align_ctrl.sv
// Sequencer for a B-PE systolic alignment array: loads B query bases, then streams 2L reference steps.
// A pass takes B+1 load cycles, 1 prefetch cycle, 2L run steps and 1 finish cycle.
// hold freezes run steps and suppresses reference reads; it is ignored while loading; abort cancels.
module align_ctrl #(
   parameter int B = 4,
   parameter int L = 16
) (
   input logic         clk,
   input logic         reset,
   align_ctrl_if.slave bus
);
   localparam int             LW        = $clog2(B + 1);
   localparam int             RW        = 2 * B;
   localparam logic [7:0]     L_C       = 8'(L);
   localparam logic [7:0]     LAST_C    = 8'(2 * L - 1);
   localparam logic [7:0]     B_C       = 8'(B);
   localparam logic [7:0]     DRAIN_C   = 8'(2 * L - B);
   localparam logic [LW-1:0]  LOAD_LAST = LW'(B);

   typedef enum logic [2:0] {IDLE, LOAD, PRE, RUN, FIN} state_t;

   state_t         state;
   logic [LW-1:0]  lcnt;
   logic [7:0]     ctr_q;
   logic [RW-1:0]  r_q;
   logic [RW-1:0]  q_q;
   logic [1:0]     r_in;
   logic           ref_step;

   // Once the reference has been fully streamed, zeros are fed in so the array drains.
   assign r_in = (ctr_q < L_C) ? bus.ref_rdata : 2'b00;

   // Pass sequencing plus the counter and PE base registers it owns.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         lcnt  <= '0;
         ctr_q <= '0;
         r_q   <= '0;
         q_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  state <= LOAD;
                  lcnt  <= '0;
                  ctr_q <= '0;
                  r_q   <= '0;
                  q_q   <= '0;
               end
            end
            LOAD: begin
               if (bus.abort) begin
                  state <= IDLE;
               end else begin
                  // Data for the strobe issued in load cycle k arrives in cycle k+1.
                  for (int k = 0; k < B; k++) begin
                     if (lcnt == LW'(k + 1)) q_q[2*k +: 2] <= bus.qry_rdata;
                  end
                  if (lcnt == LOAD_LAST) state <= PRE;
                  else                   lcnt  <= lcnt + LW'(1);
               end
            end
            PRE: begin
               state <= bus.abort ? IDLE : RUN;
            end
            RUN: begin
               if (bus.abort) begin
                  state <= IDLE;
               end else if (!bus.hold) begin
                  r_q <= (r_q << 2) | RW'(r_in);
                  if (ctr_q == LAST_C) state <= FIN;
                  else                 ctr_q <= ctr_q + 8'd1;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Read strobes follow the state directly so hold can suppress a reference fetch in the same cycle.
   always_comb begin
      ref_step      = (state == RUN) && !bus.hold && (ctr_q < L_C - 8'd1);
      bus.qry_rd_en = (state == LOAD) && (lcnt < LOAD_LAST);
      bus.qry_addr  = bus.qry_rd_en ? 8'(lcnt) : 8'd0;
      bus.ref_rd_en = (state == PRE) || ref_step;
      bus.ref_addr  = ref_step ? (ctr_q + 8'd1) : 8'd0;
   end

   // Array phase decode: fill while the wavefront enters, steady in the middle, drain at the tail.
   always_comb begin
      bus.region = 2'b00;
      bus.diag   = 2'b00;
      if (state == RUN) begin
         if (ctr_q < B_C) begin
            bus.region = 2'b01;
            bus.diag   = 2'b01;
         end else if (ctr_q < DRAIN_C) begin
            bus.region = 2'b10;
            bus.diag   = ctr_q[0] ? 2'b10 : 2'b11;
         end else begin
            bus.region = 2'b11;
            bus.diag   = 2'b01;
         end
      end
   end

   assign bus.ctr   = ctr_q;
   assign bus.r_bus = r_q;
   assign bus.q_bus = q_q;
   assign bus.busy  = (state != IDLE);
   assign bus.done  = (state == FIN) && !bus.abort;

endmodule
